dac_spi_multi: RTL and testbench

DAC_SPI_MULTI -- requirements
Module: dac_spi_multi

---
 rtl/dac_spi_multi.sv | 109 ++++++++++
 tb/tb_dac_spi_multi.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel SPI DAC driver with on-write, scan, power-down and idle modes
module dac_spi_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int CLK_DIV = 2,
  parameter int FRAME_W = 16,
  parameter int GAP_CYC = 4,
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              frame_done,
  output logic              sclk,
  output logic              sync,
  output logic              dac_din
);
  localparam int CW = 16;
  localparam int BW = $clog2(FRAME_W + 1);
  localparam int PAD = FRAME_W - 2 - CH_W - DATA_W;
  localparam logic [1:0] M_WRITE = 2'b00, M_SCAN = 2'b01, M_PD = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic ph;
  logic [BW-1:0] bits;
  logic [FRAME_W-1:0] shreg, frame;
  logic [DATA_W-1:0] regs [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0] scan, low_ch, start_ch;
  logic pd_sent, start, div_end, gap_end, last_bit, load, wr_ok;

  assign div_end = cnt == CW'(CLK_DIV - 1);
  assign gap_end = cnt == CW'(GAP_CYC - 1);
  assign last_bit = bits == BW'(FRAME_W - 1);
  assign wr_ok = wr_en && (32'(wr_ch) < NUM_CH);
  assign load = nstate == LOAD && state != LOAD;

  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pending[i]) low_ch = CH_W'(i);
  end

  // Start decision shared by IDLE and the end of GAP, so back-to-back frames keep the exact gap
  always_comb begin
    start = mode == M_WRITE ? |pending : mode == M_SCAN ? 1'b1 : mode == M_PD ? !pd_sent : 1'b0;
    start_ch = mode == M_SCAN ? scan : low_ch;
    frame = mode == M_PD ? {2'b11, {(FRAME_W-2){1'b0}}}
                         : FRAME_W'({2'b00, start_ch, regs[start_ch]}) << PAD;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) state <= IDLE;
    else state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = start ? LOAD : IDLE;
      LOAD:    nstate = div_end ? SHIFT : LOAD;
      SHIFT:   nstate = (div_end && ph && last_bit) ? GAP : SHIFT;
      GAP:     nstate = gap_end ? (start ? LOAD : IDLE) : GAP;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    sclk = !(state == SHIFT && !ph);
    sync = !(state == LOAD || state == SHIFT);
    dac_din = !sync && shreg[FRAME_W-1];
    busy = state != IDLE;
    frame_done = state == GAP && cnt == '0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt <= '0;
      ph <= 1'b0;
      bits <= '0;
      shreg <= '0;
      regs <= '{default: '0};
      pending <= '0;
      scan <= '0;
      pd_sent <= 1'b0;
    end else begin
      cnt <= (state != nstate || (state == SHIFT && div_end)) ? '0 : cnt + 1'b1;
      ph <= state == SHIFT ? ph ^ div_end : 1'b0;
      bits <= state != SHIFT ? '0 : (div_end && ph) ? bits + 1'b1 : bits;
      // Data advances on the sclk rising edge so the DAC sees it stable at the falling edge
      if (load) shreg <= frame;
      else if (state == SHIFT && div_end && !ph) shreg <= shreg << 1;
      if (load && mode == M_WRITE) pending[start_ch] <= 1'b0;
      if (load && mode == M_SCAN) scan <= scan == CH_W'(NUM_CH - 1) ? '0 : scan + 1'b1;
      pd_sent <= mode != M_PD ? 1'b0 : (pd_sent || load);
      if (wr_ok) begin
        regs[wr_ch] <= wr_data;
        if (mode == M_WRITE) pending[wr_ch] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dac_spi_multi.sv
// tb_dac_spi_multi: scoreboard bench decoding SPI frames off the pins and checking timing
module tb_dac_spi_multi;
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic [0:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] mode = 2'b11;
  logic busy, frame_done, sclk, sync, dac_din;

  logic w3_en = 1'b0;
  logic [1:0] w3_ch = '0;
  logic [7:0] w3_data = '0;
  logic [1:0] mode3 = 2'b00;
  logic busy3, done3, sclk3, sync3, din3;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  dac_spi_multi dut (
    .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .mode(mode),
    .busy(busy), .frame_done(frame_done), .sclk(sclk), .sync(sync), .dac_din(dac_din)
  );

  dac_spi_multi #(.NUM_CH(3)) dut3 (
    .clk_in(clk_in), .rst(rst), .wr_en(w3_en), .wr_ch(w3_ch), .wr_data(w3_data), .mode(mode3),
    .busy(busy3), .frame_done(done3), .sclk(sclk3), .sync(sync3), .dac_din(din3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] sh = '0;
  logic psync = 1'b1, psclk = 1'b1, pdin = 1'b0, din_bad = 1'b0;
  int low_cnt = 0, hi_cnt = 0, nbits = 0, last_gap = 0, rx_cnt = 0;

  // Pin-level receiver: samples on sclk falling edges and scores each completed frame
  always @(negedge clk_in) begin
    if (psync && !sync) begin
      last_gap = hi_cnt;
      low_cnt = 0;
      nbits = 0;
      din_bad = 1'b0;
    end
    if (!sync) begin
      low_cnt++;
      if (psclk && !sclk) begin
        sh = {sh[14:0], dac_din};
        nbits++;
      end
      if (!psync && dac_din != pdin && !(!psclk && sclk)) din_bad = 1'b1;
    end
    if (!psync && sync) begin
      hi_cnt = 1;
      if (!rst) chk("abort_no_done", 32'(frame_done), 0);
      else begin
        rx_cnt++;
        if (exp_q.size() == 0) chk("unexpected_frame", 32'(sh), 32'hFFFF_FFFF);
        else chk("frame", 32'(sh), 32'(exp_q.pop_front()));
        chk("sync_low_cycles", low_cnt, 66);
        chk("bit_count", nbits, 16);
        chk("din_on_rise_only", 32'(din_bad), 0);
        chk("frame_done_at_rise", 32'(frame_done), 1);
      end
    end else begin
      if (sync) hi_cnt++;
      if (frame_done) chk("stray_frame_done", 32'(frame_done), 0);
    end
    psync = sync;
    psclk = sclk;
    pdin = dac_din;
  end

  logic [15:0] sh3 = '0, frame3 = '0;
  logic psync3 = 1'b1, psclk3 = 1'b1;
  int got3 = 0;

  always @(negedge clk_in) begin
    if (!sync3 && psclk3 && !sclk3) sh3 = {sh3[14:0], din3};
    if (!psync3 && sync3) begin
      frame3 = sh3;
      got3++;
    end
    psync3 = sync3;
    psclk3 = sclk3;
  end

  task automatic wr(input int ch, input int d);
    @(posedge clk_in); #1;
    wr_en = 1'b1;
    wr_ch = 1'(ch);
    wr_data = 8'(d);
    @(posedge clk_in); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    repeat (3) @(negedge clk_in);
    for (n = 0; n < maxc && busy; n++) @(negedge clk_in);
    if (n >= maxc) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_rx(input int target, input int maxc, output int busy_low);
    int n;
    busy_low = 0;
    for (n = 0; n < maxc && rx_cnt < target; n++) begin
      @(negedge clk_in);
      if (!busy) busy_low++;
    end
    if (n >= maxc) chk("rx_timeout", rx_cnt, target);
  endtask

  typedef struct {
    int ch;
    int data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bl, base, n;
    vecs[0] = '{1, 185, 16'h3720};
    vecs[1] = '{0, 92, 16'h0B80};
    vecs[2] = '{0, 255, 16'h1FE0};
    vecs[3] = '{1, 0, 16'h2000};
    vecs[4] = '{1, 255, 16'h3FE0};
    vecs[5] = '{0, 1, 16'h0020};

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_sclk", 32'(sclk), 1);
    chk("rst_sync", 32'(sync), 1);
    chk("rst_din", 32'(dac_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    rst = 1'b1;
    mode = 2'b00;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      wr(vecs[i].ch, vecs[i].data);
      wait_idle(500);
      chk("vec_sb_drained", exp_q.size(), 0);
    end

    // In-flight frame is unaffected by writes; both new pendings served lowest first
    exp_q.push_back(16'h3540);
    wr(1, 8'hAA);
    repeat (20) @(posedge clk_in);
    exp_q.push_back(16'h0B80);
    exp_q.push_back(16'h3720);
    wr(1, 185);
    wr(0, 92);
    wait_idle(800);
    chk("pending_sb_drained", exp_q.size(), 0);
    chk("gap_cycles", last_gap, 4);

    // Continuous scan with a mid-frame rewrite of channel 1
    base = rx_cnt;
    exp_q.push_back(16'h0B80);
    exp_q.push_back(16'h3720);
    exp_q.push_back(16'h0B80);
    exp_q.push_back(16'h2B80);
    exp_q.push_back(16'h0B80);
    @(posedge clk_in); #1;
    mode = 2'b01;
    wait_rx(base + 2, 400, bl);
    repeat (20) @(posedge clk_in);
    wr(1, 92);
    wait_rx(base + 5, 600, bl);
    mode = 2'b11;
    chk("scan_busy_low_cycles", bl, 0);
    chk("scan_gap_cycles", last_gap, 4);
    wait_idle(200);
    chk("scan_sb_drained", exp_q.size(), 0);

    base = rx_cnt;
    exp_q.push_back(16'hC000);
    @(posedge clk_in); #1;
    mode = 2'b10;
    wait_idle(300);
    repeat (100) @(posedge clk_in);
    #1;
    chk("pd_single_frame", rx_cnt - base, 1);
    chk("pd_sync_high", 32'(sync), 1);
    chk("pd_busy_low", 32'(busy), 0);
    mode = 2'b11;

    @(posedge clk_in); #1;
    rst = 1'b0;
    mode = 2'b10;
    repeat (3) @(posedge clk_in);
    #1;
    exp_q.push_back(16'hC000);
    rst = 1'b1;
    wait_idle(300);
    chk("pd_after_reset_sb", exp_q.size(), 0);

    // Reset in the middle of a frame aborts it cleanly
    @(posedge clk_in); #1;
    mode = 2'b00;
    base = rx_cnt;
    wr(1, 185);
    for (n = 0; n < 200 && nbits < 8; n++) @(negedge clk_in);
    if (n >= 200) chk("bit8_timeout", nbits, 8);
    rst = 1'b0;
    @(posedge clk_in); #1;
    chk("abort_sync", 32'(sync), 1);
    chk("abort_sclk", 32'(sclk), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(frame_done), 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b1;
    chk("abort_no_frame", rx_cnt - base, 0);
    exp_q.push_back(16'h0B80);
    wr(0, 92);
    wait_idle(500);
    chk("post_abort_sb", exp_q.size(), 0);

    // Out-of-range channel on a 3-channel build is dropped
    @(posedge clk_in); #1;
    w3_en = 1'b1;
    w3_ch = 2'd3;
    w3_data = 8'h55;
    @(posedge clk_in); #1;
    w3_en = 1'b0;
    bl = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (busy3) bl++;
    end
    chk("bad_ch_no_frame", bl + got3, 0);
    @(posedge clk_in); #1;
    w3_en = 1'b1;
    w3_ch = 2'd2;
    w3_data = 8'hA5;
    @(posedge clk_in); #1;
    w3_en = 1'b0;
    for (n = 0; n < 300 && got3 == 0; n++) @(negedge clk_in);
    chk("ch3_frame_count", got3, 1);
    chk("ch3_frame", 32'(frame3), 32'h2A50);

    chk("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
